// File: rtl/seq_detector_param_if.sv
// Serial detector bus: qualified input bit stream, mode/clear controls and match status.
// LEN and CNT_W must match the attached seq_detector_param instance.
interface seq_detector_param_if #(
    parameter int LEN   = 3,
    parameter int CNT_W = 8
);
    logic                    in_valid;
    logic                    in;
    logic                    overlap;
    logic                    cnt_clr;
    logic                    OP;
    logic [$clog2(LEN)-1:0]  fill;
    logic [CNT_W-1:0]        match_cnt;

    modport master (
        output in_valid, in, overlap, cnt_clr,
        input  OP, fill, match_cnt
    );

    modport slave (
        input  in_valid, in, overlap, cnt_clr,
        output OP, fill, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector (Mealy OP, overlap/non-overlap, gap-transparent).
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_cnt reads 0.
module seq_detector_param #(
    parameter int             LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = 3'b101,
    parameter int             CNT_W   = 8
) (
    input logic                 clk,
    input logic                 rst,
    seq_detector_param_if.slave bus
);
    localparam int FW = $clog2(LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(LEN - 1);

    logic [LEN-2:0] hist;
    logic [FW-1:0]  fill;
    logic [LEN-1:0] window;
    logic           op;

    // Window is the full candidate pattern; its low LEN-1 bits are also the shifted history.
    always_comb begin
        window = {hist, bus.in};
        op     = bus.in_valid & ~rst & (fill == FILL_MAX) & (window == PATTERN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (bus.in_valid) begin
            if (op && !bus.overlap) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= window[LEN-2:0];
                if (fill != FILL_MAX)
                    fill <= fill + 1'b1;
            end
        end
    end

    assign bus.OP   = op;
    assign bus.fill = fill;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt;

    // Clear takes priority, then a same-cycle match counts as the first one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (bus.cnt_clr)
            cnt <= op ? CNT_W'(1) : '0;
        else if (op && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign bus.match_cnt = cnt;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = bus.cnt_clr;
    assign bus.match_cnt  = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: three detector instances share one random/directed stream and are
// compared every cycle against a queue-based model of the accepted bit history.
`timescale 1ns/1ps
module tb_seq_detector_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v = 1'b0, d = 1'b0, ov = 1'b0, clr = 1'b0;
    bit   rst_hit = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    always #10 clk = ~clk;

    seq_detector_param_if #(.LEN(3), .CNT_W(8)) b0 ();
    seq_detector_param_if #(.LEN(5), .CNT_W(8)) b1 ();
    seq_detector_param_if #(.LEN(3), .CNT_W(2)) b2 ();

    assign b0.in_valid = v;  assign b0.in = d;  assign b0.overlap = ov;  assign b0.cnt_clr = clr;
    assign b1.in_valid = v;  assign b1.in = d;  assign b1.overlap = ov;  assign b1.cnt_clr = clr;
    assign b2.in_valid = v;  assign b2.in = d;  assign b2.overlap = ov;  assign b2.cnt_clr = clr;

    seq_detector_param #(.LEN(3), .PATTERN(3'b101),   .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
    seq_detector_param #(.LEN(5), .PATTERN(5'b11011), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
    seq_detector_param #(.LEN(3), .PATTERN(3'b101),   .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

    logic op_a[3];
    int   fill_a[3];
    int   mc_a[3];
    assign op_a[0] = b0.OP;  assign fill_a[0] = int'(b0.fill);  assign mc_a[0] = int'(b0.match_cnt);
    assign op_a[1] = b1.OP;  assign fill_a[1] = int'(b1.fill);  assign mc_a[1] = int'(b1.match_cnt);
    assign op_a[2] = b2.OP;  assign fill_a[2] = int'(b2.fill);  assign mc_a[2] = int'(b2.match_cnt);

    // Model: accepted bits since the last reset/non-overlap restart, newest last.
    int L[3] = '{3, 5, 3};
    int P[3] = '{5, 27, 5};
    int W[3] = '{8, 8, 2};
    int q[3][$];
    int cnt[3] = '{0, 0, 0};

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    function automatic int model_op(int k);
        int val;
        if (!v || rst) return 0;
        if (q[k].size() != L[k] - 1) return 0;
        val = 0;
        for (int i = 0; i < q[k].size(); i++) val = val * 2 + q[k][i];
        val = val * 2 + int'(d);
        return (val == P[k]) ? 1 : 0;
    endfunction

    function automatic int exp_cnt(int k);
`ifdef SEQDET_COUNT_EN
        return cnt[k];
`else
        return 0;
`endif
    endfunction

    // Per-cycle compare, mid low phase with inputs settled.
    initial forever begin
        @(negedge clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("op%0d", k), int'(op_a[k]), model_op(k));
            chk($sformatf("fill%0d", k), fill_a[k], q[k].size());
            chk($sformatf("cnt%0d", k), mc_a[k], exp_cnt(k));
        end
    end

    always @(posedge clk) begin
        if (rst || rst_hit) begin
            for (int k = 0; k < 3; k++) begin
                q[k].delete();
                cnt[k] = 0;
            end
            rst_hit = 1'b0;
        end
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                int o;
                o = model_op(k);
                if (clr) cnt[k] = o;
                else if (o == 1 && cnt[k] < (1 << W[k]) - 1) cnt[k] = cnt[k] + 1;
                if (v) begin
                    if (o == 1 && !ov) q[k].delete();
                    else begin
                        q[k].push_back(int'(d));
                        if (q[k].size() > L[k] - 1) void'(q[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input bit iv, input bit id, input bit iov, input bit iclr);
        @(negedge clk);
        v = iv; d = id; ov = iov; clr = iclr;
        #3;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        v = 1'b0; clr = 1'b0;
        #4 rst = 1'b1; rst_hit = 1'b1;
        #2 rst = 1'b0;
        #1;
    endtask

    function automatic int cnt_lit(int n);
`ifdef SEQDET_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    initial begin
        int s1[5]  = '{1, 0, 1, 0, 1};
        int e1[5]  = '{0, 0, 1, 0, 1};
        int e2[7]  = '{0, 0, 1, 0, 0, 0, 1};
        int s6[8]  = '{1, 1, 0, 1, 1, 0, 1, 1};
        int e6[8]  = '{0, 0, 0, 0, 1, 0, 0, 1};

        repeat (3) @(negedge clk);
        #3;
        chk("reset_op", int'(op_a[0]), 0);
        chk("reset_fill", fill_a[0], 0);
        chk("reset_cnt", mc_a[0], 0);
        @(negedge clk);
        rst = 1'b0;

        // Overlapping 10101
        rst_pulse();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, s1[i][0], 1'b1, 1'b0);
            chk($sformatf("t1_op_bit%0d", i + 1), int'(op_a[0]), e1[i]);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_cnt", mc_a[0], cnt_lit(2));

        // Non-overlapping 1010101
        rst_pulse();
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, (i % 2 == 0), 1'b0, 1'b0);
            chk($sformatf("t2_op_bit%0d", i + 1), int'(op_a[0]), e2[i]);
            if (i == 3) chk("t2_fill_after3", fill_a[0], 0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_cnt", mc_a[0], cnt_lit(2));

        // Gaps with in toggling
        rst_pulse();
        cyc(1'b1, 1'b1, 1'b1, 1'b0); chk("t3_op_a", int'(op_a[0]), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("t3_op_gap1", int'(op_a[0]), 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0); chk("t3_op_b", int'(op_a[0]), 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0); chk("t3_op_gap2", int'(op_a[0]), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("t3_op_gap3", int'(op_a[0]), 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0); chk("t3_op_c", int'(op_a[0]), 1);

        // Reset mid-pattern
        rst_pulse();
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        rst_pulse();
        cyc(1'b1, 1'b1, 1'b1, 1'b0); chk("t4_op", int'(op_a[0]), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_fill", fill_a[0], 1);
        chk("t4_cnt", mc_a[0], 0);

        // Saturation on the 2-bit counter, then clear colliding with a match
        rst_pulse();
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_sat", mc_a[2], cnt_lit(3));
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1); chk("t5_clr_op", int'(op_a[2]), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_clr_cnt", mc_a[2], cnt_lit(1));

        // LEN=5 pattern 11011
        rst_pulse();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, s6[i][0], 1'b1, 1'b0);
            chk($sformatf("t6_op_bit%0d", i + 1), int'(op_a[1]), e6[i]);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_fill", fill_a[1], 4);

        // Random traffic
        repeat (3000) begin
            if ($urandom_range(0, 99) == 0) rst_pulse();
            else cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                     $urandom_range(0, 19) == 0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #4;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
